// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD accumulator.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: s = (a + b + cin) mod 10, cout on decimal overflow.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum_s;
  logic [4:0] adj_s;

  // Binary sum then decimal correction when the digit exceeds nine.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj_s = sum_s - 5'd10;
    if (sum_s > {1'b0, BCD_MAX}) begin
      s    = adj_s[3:0];
      cout = 1'b1;
    end else begin
      s    = sum_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_accumulator.sv
// Running multi-digit BCD total; each add edge sums a two-digit operand in,
// one digit per clock, so the carry ripples across cycles.
module bcd_accumulator
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add,
  input  logic                  clr,
  input  logic [7:0]            operand,
  output logic [4*DIGITS-1:0]   acc,
  output logic                  busy,
  output logic                  ovf,
  output logic                  err
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic                add_q, add_d;
  logic [7:0]          opd_q, opd_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [4*DIGITS-1:0] acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                req_s;
  logic [3:0]          acc_dig_s;
  logic [3:0]          opd_dig_s;
  logic [3:0]          sum_dig_s;
  logic                cout_s;

  assign req_s = add & ~add_q;

  // Select the accumulator and operand digits addressed by idx.
  always_comb begin
    acc_dig_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        acc_dig_s = acc_q[4*i +: 4];
      end else begin
        acc_dig_s = acc_dig_s;
      end
    end
    if (idx_q == IDX_W'(0)) begin
      opd_dig_s = opd_q[3:0];
    end else if (idx_q == IDX_W'(1)) begin
      opd_dig_s = opd_q[7:4];
    end else begin
      opd_dig_s = 4'd0;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (acc_dig_s),
    .b    (opd_dig_s),
    .cin  (carry_q),
    .s    (sum_dig_s),
    .cout (cout_s)
  );

  // Next-state logic; clr overrides both states and drops any request.
  always_comb begin
    state_d = state_q;
    add_d   = add;
    opd_d   = opd_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (clr) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
      busy_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            if (is_bcd(operand[3:0]) && is_bcd(operand[7:4])) begin
              opd_d   = operand;
              idx_d   = '0;
              carry_d = 1'b0;
              err_d   = 1'b0;
              busy_d  = 1'b1;
              state_d = ADD;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              acc_d[4*i +: 4] = sum_dig_s;
            end else begin
              acc_d[4*i +: 4] = acc_q[4*i +: 4];
            end
          end
          carry_d = cout_s;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (cout_s) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers; add_q resets high so a held button cannot fire on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      add_q   <= 1'b1;
      opd_q   <= 8'd0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      opd_q   <= opd_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign acc  = acc_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: doc/bcd_accumulator.md
# bcd_accumulator

Sequential BCD accumulator for the DE2 switch/seven-segment labs. Sits directly upstream of the per-digit seven-segment decoders: takes a two-digit BCD operand from the switches, adds it on each button press into a running three-digit BCD total, and presents the total digit-by-digit for display. Addition is digit-serial: one BCD digit per clock, so a carry ripples across clock cycles rather than through one combinational chain.

## Interface
- DIGITS, 3, number of BCD digits held in the accumulator; must be ≥ 2.
- clk  in  1  system clock (CLOCK_50 at top level).
- rst  in  1  synchronous, active-high reset.
- add  in  1  level request, already synchronised to clk; a rising edge starts one addition.
- clr  in  1  synchronous clear of accumulator and flags; level-sensitive.
- operand  in  8  two BCD digits: [7:4] tens, [3:0] ones.
- acc  out  4*DIGITS  accumulator, BCD; digit i at [4i+3:4i].
- busy  out  1  high while an addition is in progress.
- ovf  out  1  sticky: total has exceeded 10^DIGITS − 1.
- err  out  1  sticky: last request carried a non-BCD operand.

## Operation
- States: IDLE, ADD. Registers: add_q (edge detect), opd latch (8 bits), idx (digit index), carry.
- Request = add & ~add_q, evaluated every cycle; add_q <= add every cycle.
- IDLE, request, both operand digits ≤ 9:
  - latch operand; idx <= 0; carry <= 0; err <= 0; busy <= 1; go to ADD.
- IDLE, request, either operand digit > 9:
  - err <= 1; acc and ovf unchanged; stay IDLE.
- ADD, every cycle, digit idx:
  - t = acc[idx] + o + carry, 5 bits wide; o = opd digit idx for idx < 2, else 0.
  - if t > 9: acc[idx] <= t − 10, carry <= 1; else acc[idx] <= t, carry <= 0.
  - idx < DIGITS−1: idx <= idx+1.
  - idx = DIGITS−1: go to IDLE, busy <= 0; if the final carry is 1, ovf <= 1. acc wraps modulo 10^DIGITS.
- Requests arriving in ADD are dropped, not queued; add_q still tracks add.
- clr has priority over everything in any state:
  - acc <= 0, ovf <= 0, err <= 0, busy <= 0, state <= IDLE.
  - An addition in flight is aborted.
  - clr and request in the same cycle: clr wins, request dropped.
- acc digits are always valid BCD (0–9), including mid-addition. Higher digits hold their old value until they are processed.

## Timing
- Reset values: acc = 0, busy = 0, ovf = 0, err = 0, state = IDLE, idx = 0, carry = 0.
- add_q resets to 1, so an add held high through reset does not fire on release.
- Request accepted at edge k. Digit i is updated at edge k+1+i. Final acc, busy = 0 and ovf are valid after edge k+DIGITS.
- busy is high for exactly DIGITS cycles per accepted request.
- Earliest next accepted request: edge k+DIGITS+1, which needs add low at edge k+DIGITS or earlier.
- err is set at the edge where the request is seen, with no latency beyond that edge.
- clr takes effect at the edge where it is sampled high.

## Structure
- Package bcd_pkg holds:
  - state enum (IDLE, ADD);
  - BCD_MAX = 9;
  - function is_bcd(digit), returning digit ≤ BCD_MAX.
- One sub-module, bcd_digit_add: combinational; inputs a[3:0], b[3:0], cin; outputs s[3:0], cout. Single instance, muxed by idx.
- Top level connects acc digits and the operand digits to the existing seven-segment decoders.

## Test plan
- add held at 1 through rst and released after reset deasserts -> no addition; acc = 000, busy = 0 throughout.
- Two presses with operand 0x47 -> acc = 047, then 094. busy is high for 3 cycles each time; acc[3:0] updates at k+1.
- From 094, add 0x99 -> acc = 193 at k+3. Intermediate values: 093 at k+1, 093 at k+2 (carry held), 193 at k+3.
- Ten presses of 0x99 give 990; then press with 0x10 -> acc = 000, ovf = 1. ovf stays 1 after a further press of 0x01, which gives acc = 001.
- operand 0x3A, press -> err = 1, acc unchanged, busy stays 0. Next press with 0x05 -> err = 0, acc += 5.
- clr asserted at k+2 of an addition -> acc = 000, busy = 0, ovf = 0 after that edge. clr and add rising in the same cycle -> acc = 000, no addition started.
